up_mem_arbiter: RTL and testbench

//  Shares the single-port 256x8 micro memory (async read, sync write) between two requesters.

---
 rtl/up_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_up_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/up_mem_arbiter.sv
// Purpose : round-robin arbiter sharing one 256x8 async-read/sync-write memory between two ports.
// Latency : grant in the request cycle; read data registered one cycle after the grant.
// Backpr. : a requester holds req/addr/wd/we until it sees gnt; ownership rotates after MAX_BURST
//           consecutive grants while the other port waits.
//
// Ports:
//   clk, nRst                      clock, asynchronous active-low reset
//   req0/addr0/wd0/we0 -> gnt0     port 0 (CPU) request, granted combinationally
//   rd0, rvalid0                   port 0 registered read data, 1-cycle valid pulse
//   req1/addr1/wd1/we1 -> gnt1     port 1 (debug/loader), same as port 0
//   rd1, rvalid1                   port 1 registered read data, 1-cycle valid pulse
//   mem_addr/mem_in/mem_we         memory access for the granted port (zero when idle)
//   mem_out                        memory read data, combinational on mem_addr
//   busy                           an access is issued this cycle
module up_mem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wd0,
  input  logic          we0,
  output logic          gnt0,
  output logic [DW-1:0] rd0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wd1,
  input  logic          we1,
  output logic          gnt1,
  output logic [DW-1:0] rd1,
  output logic          rvalid1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_in,
  output logic          mem_we,
  input  logic [DW-1:0] mem_out,
  output logic          busy
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE     = CW'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]    owner, owner_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          g0, g1;
  logic [1:0]    gnt_owner;

  // Grant decision. With both ports requesting, the current owner keeps the
  // memory until it has used up its burst, then the other port gets it.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (req0 && !req1) begin
      g0 = 1'b1;
    end else if (req1 && !req0) begin
      g1 = 1'b1;
    end else if (req0 && req1) begin
      case (owner)
        OWN0: begin
          if (cnt < MAX_CNT) g0 = 1'b1;
          else               g1 = 1'b1;
        end
        OWN1: begin
          if (cnt < MAX_CNT) g1 = 1'b1;
          else               g0 = 1'b1;
        end
        default: g0 = 1'b1;
      endcase
    end
  end

  // Reset must kill any access immediately, not just at the next edge.
  assign gnt0 = g0 & nRst;
  assign gnt1 = g1 & nRst;
  assign busy = gnt0 | gnt1;

  // Ownership / burst counter next state. An idle cycle forgets the owner,
  // so the next contention starts fresh with port 0.
  always_comb begin
    owner_nxt = IDLE;
    cnt_nxt   = '0;
    gnt_owner = g1 ? OWN1 : OWN0;
    if (g0 || g1) begin
      if (owner == gnt_owner) begin
        owner_nxt = owner;
        cnt_nxt   = (cnt == MAX_CNT) ? cnt : cnt + ONE;
      end else begin
        owner_nxt = gnt_owner;
        cnt_nxt   = ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      owner <= IDLE;
      cnt   <= '0;
    end else begin
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Memory mux: only the granted port reaches the memory.
  always_comb begin
    mem_addr = '0;
    mem_in   = '0;
    mem_we   = 1'b0;
    if (gnt0) begin
      mem_addr = addr0;
      mem_in   = wd0;
      mem_we   = we0;
    end else if (gnt1) begin
      mem_addr = addr1;
      mem_in   = wd1;
      mem_we   = we1;
    end
  end

  // Read return: capture the async memory output at the end of the grant
  // cycle; rd holds its value until the port's next read.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rd0     <= '0;
      rd1     <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 && !we0) rd0 <= mem_out;
      if (gnt1 && !we1) rd1 <= mem_out;
    end
  end

endmodule

// File: tb/tb_up_mem_arbiter.sv
// Purpose : self-checking bench for up_mem_arbiter, directed cases then randomized traffic.
// Latency : grants checked in the request cycle, read data one cycle later.
// Backpr. : modelled requesters hold each request until granted.
module tb_up_mem_arbiter;

  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       nRst;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wd0, addr1, wd1;
  logic       gnt0, gnt1, rvalid0, rvalid1, mem_we, busy;
  logic [7:0] rd0, rd1, mem_addr, mem_in, mem_out;

  up_mem_arbiter #(.AW(8), .DW(8), .MAX_BURST(MB)) dut (
    .clk(clk), .nRst(nRst),
    .req0(req0), .addr0(addr0), .wd0(wd0), .we0(we0), .gnt0(gnt0), .rd0(rd0), .rvalid0(rvalid0),
    .req1(req1), .addr1(addr1), .wd1(wd1), .we1(we1), .gnt1(gnt1), .rd1(rd1), .rvalid1(rvalid1),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_we(mem_we), .mem_out(mem_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seed_val(input int i);
    return 8'(i * 29 + 99);  // seed_val(1) == 8'h80
  endfunction

  // Environment memory: async read, sync write, loaded while in reset.
  logic [7:0] mem [256];
  assign mem_out = mem[mem_addr];
  always @(posedge clk) begin
    if (!nRst) begin
      for (int i = 0; i < 256; i++) mem[i] <= seed_val(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_in;
    end
  end

  // Reference model state
  logic [7:0] ref_mem [256];
  logic       p_req [2];
  logic [7:0] p_addr [2];
  logic [7:0] p_wd [2];
  logic       p_we [2];
  logic       sticky [2];
  int         last_port;   // port that got the previous grant, -1 after idle/reset
  int         streak;      // unsaturated run length of last_port
  logic       exp_rv [2];
  logic [7:0] exp_rd [2];
  int         last_g;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    last_port = -1;
    streak    = 0;
    for (int n = 0; n < 2; n++) begin
      exp_rv[n] = 1'b0;
      exp_rd[n] = 8'h00;
    end
  endtask

  task automatic drive();
    req0 = p_req[0]; addr0 = p_addr[0]; wd0 = p_wd[0]; we0 = p_we[0];
    req1 = p_req[1]; addr1 = p_addr[1]; wd1 = p_wd[1]; we1 = p_we[1];
  endtask

  task automatic set_req(input int n, input logic [7:0] a, input logic w, input logic [7:0] d);
    p_req[n] = 1'b1; p_addr[n] = a; p_we[n] = w; p_wd[n] = d;
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic step();
    int g;
    int exp_cnt;
    drive();
    @(negedge clk);
    chk("rvalid0", 32'(rvalid0), 32'(exp_rv[0]));
    chk("rvalid1", 32'(rvalid1), 32'(exp_rv[1]));
    chk("rd0", 32'(rd0), 32'(exp_rd[0]));
    chk("rd1", 32'(rd1), 32'(exp_rd[1]));
    exp_cnt = (streak > MB) ? MB : streak;
    chk("cnt", 32'(dut.cnt), 32'(exp_cnt));

    g = -1;
    if (p_req[0] && p_req[1]) begin
      if (last_port < 0)     g = 0;
      else if (streak >= MB) g = 1 - last_port;
      else                   g = last_port;
    end else if (p_req[0]) begin
      g = 0;
    end else if (p_req[1]) begin
      g = 1;
    end

    chk("gnt0", 32'(gnt0), 32'(g == 0));
    chk("gnt1", 32'(gnt1), 32'(g == 1));
    chk("busy", 32'(busy), 32'(g >= 0));
    chk("mem_we", 32'(mem_we), 32'((g >= 0) && p_we[g]));
    if (g >= 0) begin
      chk("mem_addr", 32'(mem_addr), 32'(p_addr[g]));
      if (p_we[g]) chk("mem_in", 32'(mem_in), 32'(p_wd[g]));
    end else begin
      chk("mem_addr_idle", 32'(mem_addr), 32'h0);
      chk("mem_in_idle", 32'(mem_in), 32'h0);
    end

    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    if (g >= 0) begin
      if (p_we[g]) begin
        ref_mem[p_addr[g]] = p_wd[g];
      end else begin
        exp_rv[g] = 1'b1;
        exp_rd[g] = ref_mem[p_addr[g]];
      end
      if (!sticky[g]) p_req[g] = 1'b0;
      if (g == last_port) streak++;
      else begin
        last_port = g;
        streak    = 1;
      end
    end else begin
      last_port = -1;
      streak    = 0;
    end
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p_req[0] = 1'b0; p_req[1] = 1'b0;
    sticky[0] = 1'b0; sticky[1] = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = seed_val(i);
    for (int n = 0; n < 2; n++) begin
      p_req[n] = 1'b0; p_addr[n] = 8'h00; p_wd[n] = 8'h00; p_we[n] = 1'b0; sticky[n] = 1'b0;
    end
    model_reset();
    last_g = -1;

    // Reset with both ports requesting writes: everything must stay quiet.
    nRst = 1'b0;
    req0 = 1'b1; addr0 = 8'h11; wd0 = 8'hAA; we0 = 1'b1;
    req1 = 1'b1; addr1 = 8'h22; wd1 = 8'hBB; we1 = 1'b1;
    #3;
    chk("rst_gnt0", 32'(gnt0), 32'h0);
    chk("rst_gnt1", 32'(gnt1), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid0", 32'(rvalid0), 32'h0);
    chk("rst_rvalid1", 32'(rvalid1), 32'h0);
    chk("rst_rd0", 32'(rd0), 32'h0);
    chk("rst_cnt", 32'(dut.cnt), 32'h0);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    nRst = 1'b1;
    @(posedge clk);
    #1;

    // Single read of 0x01 after reset.
    set_req(0, 8'h01, 1'b0, 8'h00);
    step();
    chk("t1_grant", 32'(last_g), 32'h0);
    chk("t1_rvalid0", 32'(rvalid0), 32'h1);
    chk("t1_rd0", 32'(rd0), 32'h80);
    idle();

    // Both ports hammering: bursts of MB alternate, starting with port 0.
    sticky[0] = 1'b1; sticky[1] = 1'b1;
    set_req(0, 8'h05, 1'b0, 8'h00);
    set_req(1, 8'h06, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("t2_burst", 32'(last_g), 32'((i / MB) % 2));
    end
    idle();

    // Port 1 write then port 0 read of the same address next cycle.
    set_req(1, 8'h80, 1'b1, 8'h5A);
    step();
    set_req(0, 8'h80, 1'b0, 8'h00);
    step();
    chk("t3_rvalid0", 32'(rvalid0), 32'h1);
    chk("t3_rd0", 32'(rd0), 32'h5A);
    idle();

    // Port 1 alone for two grants, then contention: two more for port 1.
    sticky[1] = 1'b1;
    set_req(1, 8'h30, 1'b0, 8'h00);
    step(); chk("t4_g1", 32'(last_g), 32'h1);
    step(); chk("t4_g2", 32'(last_g), 32'h1);
    set_req(0, 8'h31, 1'b0, 8'h00);
    step(); chk("t4_g3", 32'(last_g), 32'h1);
    step(); chk("t4_g4", 32'(last_g), 32'h1);
    sticky[1] = 1'b0;
    step(); chk("t4_g5", 32'(last_g), 32'h0);
    idle();
    idle();

    // Reset in the middle of a port-1 burst.
    sticky[1] = 1'b1;
    set_req(1, 8'h10, 1'b0, 8'h00);
    repeat (3) step();
    set_req(0, 8'h20, 1'b0, 8'h00);
    drive();
    #1;
    chk("t5_pre_gnt1", 32'(gnt1), 32'h1);
    chk("t5_pre_rvalid1", 32'(rvalid1), 32'h1);
    nRst = 1'b0;
    #1;
    chk("t5_gnt0", 32'(gnt0), 32'h0);
    chk("t5_gnt1", 32'(gnt1), 32'h0);
    chk("t5_mem_we", 32'(mem_we), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_rvalid1", 32'(rvalid1), 32'h0);
    chk("t5_cnt", 32'(dut.cnt), 32'h0);
    model_reset();
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    nRst = 1'b1;
    @(posedge clk);
    #1;
    step();
    chk("t5_first_after_rst", 32'(last_g), 32'h0);
    idle();
    idle();

    // Ten back-to-back reads from port 0 only.
    for (int i = 0; i < 10; i++) begin
      set_req(0, 8'(i), 1'b0, 8'h00);
      step();
    end
    idle();

    // Randomized traffic: each port issues a new request when free, with
    // addresses in a small window so read-after-write hazards are common.
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!p_req[n] && $urandom_range(0, 9) < 7)
          set_req(n, 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 8'($urandom));
      end
      step();
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
